sync_barrier_unit: RTL and testbench

Parametrised sync-group barrier and core-enable controller for the multi-core array. It tracks which sync group each core belongs to and handles core joins and spawn inheritance. It issues registered per-core go pulses: group 0 is free-running, and groups 1..NGROUPS-1 release only when every enabled member is ready. Each barrier group has a re-arm FSM, which prevents double release; the old free-running go vector lacked this.

---
 rtl/sync_barrier_unit_pkg.sv | 20 ++
 rtl/sync_barrier_unit_group_fsm.sv | 63 ++++++
 rtl/sync_barrier_unit.sv | 175 +++++++++++++++++
 tb/tb_sync_barrier_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_barrier_unit_pkg.sv
// Shared types and constants for the sync barrier unit.
// Build option SYNC_STATS_EN enables per-group release counters.
package sync_pkg;

    localparam int unsigned NCORES_DEF  = 16;
    localparam int unsigned NGROUPS_DEF = 16;
    localparam int unsigned GRP_FREE    = 0;
    localparam int unsigned MAXCORES    = 64;

    typedef enum logic {
        ARMED    = 1'b0,
        RELEASED = 1'b1
    } grp_state_e;

    // Isolates the lowest set bit; used to pick the lowest-numbered spawning parent.
    function automatic logic [MAXCORES-1:0] onehot_lowest(input logic [MAXCORES-1:0] v);
        return v & (~v + 64'd1);
    endfunction

endpackage

// File: rtl/sync_barrier_unit_group_fsm.sv
// Re-arm FSM for one barrier group: fires once when all enabled members are ready.
// Build option SYNC_STATS_EN adds a 16-bit wrapping release counter.
module sync_group_fsm
    import sync_pkg::*;
#(
    parameter int unsigned NCORES = NCORES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCORES-1:0] member_i,
    input  logic [NCORES-1:0] enable_i,
    input  logic [NCORES-1:0] ready_i,
    output logic              fire_o,
    output logic              released_o,
`ifdef SYNC_STATS_EN
    output logic [15:0]       count_o,
`endif
    output grp_state_e        state_o
);

    grp_state_e        state_q;
    logic              rel_q;
    logic [NCORES-1:0] live;
    logic              rearm;

    always_comb begin
        live   = member_i & enable_i;
        fire_o = (state_q == ARMED) && (|live) && ((live & ~ready_i) == '0);
        rearm  = ((live & ready_i) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARMED;
            rel_q   <= 1'b0;
        end else begin
            rel_q <= fire_o;
            case (state_q)
                ARMED:    if (fire_o) state_q <= RELEASED;
                RELEASED: if (rearm)  state_q <= ARMED;
                default:              state_q <= ARMED;
            endcase
        end
    end

`ifdef SYNC_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (fire_o) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign count_o = cnt_q;
`endif

    assign released_o = rel_q;
    assign state_o    = state_q;

endmodule

// File: rtl/sync_barrier_unit.sv
// Sync-group barrier and core-enable controller: membership, spawn/join, registered go pulses.
// Build option SYNC_STATS_EN enables stat_count readback of per-group release counters.
module sync_barrier_unit
    import sync_pkg::*;
#(
    parameter int unsigned NCORES    = NCORES_DEF,
    parameter int unsigned NGROUPS   = NGROUPS_DEF,
    parameter int unsigned BOOT_CORE = 0,
    parameter int unsigned IDW       = $clog2(NCORES),
    parameter int unsigned GW        = $clog2(NGROUPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCORES-1:0]         core_ready,
    input  logic [NCORES-1:0]         core_halt,
    input  logic [NCORES-1:0]         join_valid,
    input  logic [NCORES*GW-1:0]      join_group,
    input  logic [NCORES-1:0]         spawn_valid,
    input  logic [NCORES*IDW-1:0]     spawn_child,
    output logic [NCORES-1:0]         core_enable,
    output logic [NCORES-1:0]         core_go,
    output logic [NGROUPS*NCORES-1:0] group_mask,
    output logic [NGROUPS-1:0]        group_released,
    input  logic [GW-1:0]             stat_sel,
    output logic [15:0]               stat_count
);

    localparam int unsigned GSPAN = 1 << GW;
    localparam logic [NCORES-1:0] EN_RST = {{(NCORES-1){1'b0}}, 1'b1} << BOOT_CORE;

    logic [GW-1:0]     grp_q [NCORES];
    logic [GW-1:0]     grp_d [NCORES];
    logic [NCORES-1:0] en_q, en_d;
    logic [NCORES-1:0] go_q, go_d;

    logic [NCORES-1:0] mask_w [NGROUPS];
    logic [NGROUPS-1:0] fire_w;
    logic [NGROUPS-1:0] rel_w;
    grp_state_e         state_w [NGROUPS];
    logic [GSPAN-1:0]   grp_ok;

    logic [NCORES-1:0] spawn_req [NCORES];
    logic [NCORES-1:0] spawn_sel [NCORES];
    logic [NCORES-1:0] spawn_hit;
    logic [GW-1:0]     spawn_grp [NCORES];

    always_comb begin
        grp_ok = '0;
        for (int unsigned g = 0; g < GSPAN; g++) begin
            grp_ok[g] = (g < NGROUPS);
        end
    end

    always_comb begin
        group_mask = '0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            mask_w[g] = '0;
            for (int unsigned c = 0; c < NCORES; c++) begin
                mask_w[g][c] = (grp_q[c] == GW'(g));
            end
            group_mask[g*NCORES +: NCORES] = mask_w[g];
        end
    end

    // Each child collects all parents naming it; the lowest-numbered one supplies the group.
    always_comb begin
        spawn_hit = '0;
        for (int unsigned ch = 0; ch < NCORES; ch++) begin
            spawn_req[ch] = '0;
            for (int unsigned p = 0; p < NCORES; p++) begin
                spawn_req[ch][p] = spawn_valid[p] && (p != ch) &&
                                   (spawn_child[p*IDW +: IDW] == IDW'(ch));
            end
            spawn_sel[ch] = NCORES'(onehot_lowest(MAXCORES'(spawn_req[ch])));
            spawn_hit[ch] = |spawn_req[ch];
            spawn_grp[ch] = '0;
            for (int unsigned p = 0; p < NCORES; p++) begin
                spawn_grp[ch] = spawn_grp[ch] | (spawn_sel[ch][p] ? grp_q[p] : '0);
            end
        end
    end

    always_comb begin
        en_d = en_q;
        for (int unsigned c = 0; c < NCORES; c++) begin
            grp_d[c] = grp_q[c];
            if (spawn_hit[c]) begin
                en_d[c]  = 1'b1;
                grp_d[c] = spawn_grp[c];
            end else begin
                if (core_halt[c]) en_d[c] = 1'b0;
                if (join_valid[c] && grp_ok[join_group[c*GW +: GW]]) begin
                    grp_d[c] = join_group[c*GW +: GW];
                end
            end
        end
    end

    // Release decisions use pre-edge membership and enables.
    always_comb begin
        go_d = en_q & core_ready & mask_w[GRP_FREE];
        for (int unsigned g = 1; g < NGROUPS; g++) begin
            if (fire_w[g]) go_d = go_d | (mask_w[g] & en_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= EN_RST;
            go_q <= '0;
            for (int unsigned c = 0; c < NCORES; c++) begin
                grp_q[c] <= '0;
            end
        end else begin
            en_q <= en_d;
            go_q <= go_d;
            for (int unsigned c = 0; c < NCORES; c++) begin
                grp_q[c] <= grp_d[c];
            end
        end
    end

    assign fire_w[0]  = 1'b0;
    assign rel_w[0]   = 1'b0;
    assign state_w[0] = ARMED;

`ifdef SYNC_STATS_EN
    logic [15:0] cnt_w [NGROUPS];
    assign cnt_w[0] = '0;
`endif

    for (genvar g = 1; g < NGROUPS; g++) begin : g_grp
        sync_group_fsm #(
            .NCORES(NCORES)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .member_i   (mask_w[g]),
            .enable_i   (en_q),
            .ready_i    (core_ready),
            .fire_o     (fire_w[g]),
            .released_o (rel_w[g]),
`ifdef SYNC_STATS_EN
            .count_o    (cnt_w[g]),
`endif
            .state_o    (state_w[g])
        );
    end

    logic unused_state;
    always_comb begin
        unused_state = 1'b0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            unused_state = unused_state ^ (state_w[g] == RELEASED);
        end
    end

`ifdef SYNC_STATS_EN
    always_comb begin
        stat_count = '0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            if (stat_sel == GW'(g)) stat_count = cnt_w[g];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

    assign core_enable    = en_q;
    assign core_go        = go_q;
    assign group_released = rel_w;

endmodule

// File: tb/tb_sync_barrier_unit.sv
// Directed scoreboard bench for sync_barrier_unit (16 cores, 16 groups).
module tb_sync_barrier_unit;

    localparam int NC  = 16;
    localparam int NG  = 16;
    localparam int IDW = 4;
    localparam int GW  = 4;

    localparam int K_GO   = 0;
    localparam int K_EN   = 1;
    localparam int K_REL  = 2;
    localparam int K_MASK = 3;
    localparam int K_STAT = 4;

`ifdef SYNC_STATS_EN
    localparam logic [63:0] STAT_AFTER3 = 64'd3;
`else
    localparam logic [63:0] STAT_AFTER3 = 64'd0;
`endif

    logic               clk;
    logic               rst;
    logic [NC-1:0]      core_ready;
    logic [NC-1:0]      core_halt;
    logic [NC-1:0]      join_valid;
    logic [NC*GW-1:0]   join_group;
    logic [NC-1:0]      spawn_valid;
    logic [NC*IDW-1:0]  spawn_child;
    logic [NC-1:0]      core_enable;
    logic [NC-1:0]      core_go;
    logic [NG*NC-1:0]   group_mask;
    logic [NG-1:0]      group_released;
    logic [GW-1:0]      stat_sel;
    logic [15:0]        stat_count;

    sync_barrier_unit #(
        .NCORES    (NC),
        .NGROUPS   (NG),
        .BOOT_CORE (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .core_ready     (core_ready),
        .core_halt      (core_halt),
        .join_valid     (join_valid),
        .join_group     (join_group),
        .spawn_valid    (spawn_valid),
        .spawn_child    (spawn_child),
        .core_enable    (core_enable),
        .core_go        (core_go),
        .group_mask     (group_mask),
        .group_released (group_released),
        .stat_sel       (stat_sel),
        .stat_count     (stat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [63:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [63:0] observe(input int kind, input int idx);
        case (kind)
            K_GO:    return 64'(core_go);
            K_EN:    return 64'(core_enable);
            K_REL:   return 64'(group_released);
            K_MASK:  return 64'(group_mask[idx*NC +: NC]);
            default: return 64'(stat_count);
        endcase
    endfunction

    task automatic expect_v(input string tag, input int kind, input int idx, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t        e;
        logic [63:0] obs;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.kind, e.idx);
            total++;
            assert (obs === e.exp) passed++;
            else $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic clr();
        core_halt   = '0;
        join_valid  = '0;
        join_group  = '0;
        spawn_valid = '0;
        spawn_child = '0;
    endtask

    task automatic do_join(input int c, input int g);
        join_valid[c]             = 1'b1;
        join_group[c*GW +: GW]    = GW'(g);
    endtask

    task automatic do_spawn(input int p, input int ch);
        spawn_valid[p]              = 1'b1;
        spawn_child[p*IDW +: IDW]   = IDW'(ch);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; core_ready = '0; stat_sel = '0;
        clr();
        step();
        expect_v("rst_en", K_EN, 0, 64'h0001);
        expect_v("rst_go", K_GO, 0, 64'h0);
        expect_v("rst_rel", K_REL, 0, 64'h0);
        expect_v("rst_mask0", K_MASK, 0, 64'hFFFF);
        expect_v("rst_mask4", K_MASK, 4, 64'h0);
        expect_v("rst_stat", K_STAT, 0, 64'h0);
        step();

        rst = 1'b0; core_ready = 16'h0001;
        expect_v("g0_go1", K_GO, 0, 64'h0001);
        step();
        expect_v("g0_go2", K_GO, 0, 64'h0001);
        expect_v("g0_en", K_EN, 0, 64'h0001);
        step();

        do_spawn(0, 3);
        expect_v("spawn3_en", K_EN, 0, 64'h0009);
        expect_v("spawn3_go", K_GO, 0, 64'h0001);
        step();
        clr(); do_spawn(3, 7);
        expect_v("spawn7_en", K_EN, 0, 64'h0089);
        expect_v("spawn7_mask0", K_MASK, 0, 64'hFFFF);
        step();

        clr(); core_ready = '0;
        do_spawn(0, 1); do_spawn(3, 2); do_spawn(7, 5);
        expect_v("spawn125_en", K_EN, 0, 64'h00AF);
        expect_v("spawn125_go", K_GO, 0, 64'h0);
        step();
        clr(); do_join(1, 4); do_join(2, 4); do_join(5, 4);
        expect_v("join_mask4", K_MASK, 4, 64'h0026);
        expect_v("join_mask0", K_MASK, 0, 64'hFFD9);
        step();

        clr(); core_ready = 16'h0002;
        expect_v("bar_r1_go", K_GO, 0, 64'h0);
        step();
        core_ready = 16'h0006;
        expect_v("bar_r2_go", K_GO, 0, 64'h0);
        expect_v("bar_r2_rel", K_REL, 0, 64'h0);
        step();
        core_ready = 16'h0026;
        expect_v("bar_fire_go", K_GO, 0, 64'h0026);
        expect_v("bar_fire_rel", K_REL, 0, 64'h0010);
        step();
        expect_v("bar_hold_go", K_GO, 0, 64'h0);
        expect_v("bar_hold_rel", K_REL, 0, 64'h0);
        step();
        expect_v("bar_hold2_go", K_GO, 0, 64'h0);
        step();
        core_ready = '0;
        expect_v("bar_rearm_go", K_GO, 0, 64'h0);
        step();
        core_ready = 16'h0026;
        expect_v("bar2_go", K_GO, 0, 64'h0026);
        expect_v("bar2_rel", K_REL, 0, 64'h0010);
        step();
        core_ready = '0;
        expect_v("bar2_drop_go", K_GO, 0, 64'h0);
        step();

        do_spawn(2, 9); do_spawn(6, 9); do_join(9, 3); core_halt[9] = 1'b1;
        expect_v("conf_en", K_EN, 0, 64'h02AF);
        expect_v("conf_mask4", K_MASK, 4, 64'h0226);
        expect_v("conf_mask3", K_MASK, 3, 64'h0);
        step();

        clr(); core_halt = 16'h0220;
        expect_v("halt_en", K_EN, 0, 64'h008F);
        expect_v("halt_mask4", K_MASK, 4, 64'h0226);
        step();
        clr(); core_ready = 16'h0006;
        expect_v("dis_go", K_GO, 0, 64'h0006);
        expect_v("dis_rel", K_REL, 0, 64'h0010);
        step();
        core_ready = '0; stat_sel = 4'd4;
        expect_v("dis_drop_go", K_GO, 0, 64'h0);
        expect_v("stat3", K_STAT, 0, STAT_AFTER3);
        step();

        do_spawn(10, 10);
        expect_v("selfspawn_en", K_EN, 0, 64'h008F);
        step();
        clr();

        core_ready = 16'h0001;
        expect_v("pre_rst_go", K_GO, 0, 64'h0001);
        step();
        rst = 1'b1;
        expect_v("mid_rst_en", K_EN, 0, 64'h0001);
        expect_v("mid_rst_go", K_GO, 0, 64'h0);
        expect_v("mid_rst_mask0", K_MASK, 0, 64'hFFFF);
        expect_v("mid_rst_mask4", K_MASK, 4, 64'h0);
        expect_v("mid_rst_stat", K_STAT, 0, 64'h0);
        step();
        rst = 1'b0;
        expect_v("post_rst_go", K_GO, 0, 64'h0001);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
